// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the cost-table responder.
package jam_pkg;

  // Workers = jobs; index math relies on 3-bit worker/job fields.
  localparam int N            = 8;
  localparam int COST_W       = 7;
  localparam int COST_MAX     = 100;

  // 8 rows x 100 max = 800 fits 10 bits; 64 x 100 = 6400 fits 13 bits.
  localparam int LB_W         = 10;
  localparam int CSUM_W       = 13;

  // Running row minimum restarts from the largest 7-bit value.
  localparam int ROW_MIN_INIT = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/jam_row_min.sv
// Running minimum of the current row. The minimum including the entry
// being accepted is presented combinationally so the parent can fold it
// into the lower bound on the last column of each row.
module jam_row_min
  import jam_pkg::*;
#(
  parameter int COST_W = jam_pkg::COST_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_clear,     // start of a new load
  input  logic              i_acc,       // an entry is accepted this cycle
  input  logic              i_col_last,  // accepted entry is column 7 of its row
  input  logic [COST_W-1:0] i_d,         // saturated entry value
  output logic [COST_W-1:0] o_row_min    // min(row so far, i_d)
);

  logic [COST_W-1:0] r_row_min;
  logic [COST_W-1:0] w_min;

  assign w_min     = (i_d < r_row_min) ? i_d : r_row_min;
  assign o_row_min = w_min;

  // Track the row minimum; restart it after each completed row or new load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_row_min <= COST_W'(ROW_MIN_INIT);
    end else if (i_clear) begin
      r_row_min <= COST_W'(ROW_MIN_INIT);
    end else if (i_acc) begin
      r_row_min <= i_col_last ? COST_W'(ROW_MIN_INIT) : w_min;
    end
  end

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 worker/job cost table. Loaded once from a row-major byte stream,
// then answers (W, J) -> Cost lookups combinationally. The checksum and
// the per-row-minimum lower bound are accumulated while loading.
//
// Load handshake: an entry transfers on a rising edge where
// ld_valid & ld_ready are both high; ld_ready is high only in LOAD.
// ld_valid outside LOAD is ignored. ld_start takes priority over a
// transfer in the same cycle: the datum is dropped and the load restarts
// at entry 0.
module jam_cost_table
  import jam_pkg::*;
#(
  parameter int COST_W   = jam_pkg::COST_W,
  parameter int COST_MAX = jam_pkg::COST_MAX,
  parameter int N        = jam_pkg::N
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              table_valid,
  output logic              ld_err,
  output logic [CSUM_W-1:0] checksum,
  output logic [LB_W-1:0]   lower_bound,
  output logic [1:0]        dbg_state
);

  localparam int ENTRIES = N * N;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int COL_W   = $clog2(N);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [COST_W-1:0] r_mem [ENTRIES];
  logic [CSUM_W-1:0] r_checksum;
  logic [LB_W-1:0]   r_lower_bound;
  logic              r_ld_err;

  logic              w_accept;
  logic              w_over;
  logic [COST_W-1:0] w_d;
  logic              w_col_last;
  logic              w_last;
  logic [COST_W-1:0] w_row_min;

  assign ld_ready    = (r_state == LOAD);
  assign table_valid = (r_state == READY);
  assign dbg_state   = r_state;

  // ld_start wins over a coincident transfer.
  assign w_accept   = ld_valid & ld_ready & ~ld_start;
  assign w_over     = (ld_data > COST_W'(COST_MAX));
  assign w_d        = w_over ? COST_W'(COST_MAX) : ld_data;
  assign w_col_last = (r_idx[COL_W-1:0] == COL_W'(N - 1));
  assign w_last     = (r_idx == IDX_W'(ENTRIES - 1));

  assign Cost        = table_valid ? r_mem[{W, J}] : '0;
  assign checksum    = r_checksum;
  assign lower_bound = r_lower_bound;
  assign ld_err      = r_ld_err;

  jam_row_min #(
    .COST_W     (COST_W)
  ) u_row_min (
    .CLK        (CLK),
    .RST        (RST),
    .i_clear    (ld_start),
    .i_acc      (w_accept),
    .i_col_last (w_col_last),
    .i_d        (w_d),
    .o_row_min  (w_row_min)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: ld_start always (re)enters LOAD; entry 63 completes it.
  always_comb begin
    w_state_nxt = r_state;
    if (ld_start) begin
      w_state_nxt = LOAD;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        LOAD:    if (w_accept && w_last) w_state_nxt = READY;
        READY:   w_state_nxt = READY;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Load index, checksum, lower bound and saturation flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx         <= '0;
      r_checksum    <= '0;
      r_lower_bound <= '0;
      r_ld_err      <= 1'b0;
    end else if (ld_start) begin
      r_idx         <= '0;
      r_checksum    <= '0;
      r_lower_bound <= '0;
      r_ld_err      <= 1'b0;
    end else if (w_accept) begin
      r_idx      <= r_idx + IDX_W'(1);
      r_checksum <= r_checksum + CSUM_W'(w_d);
      r_ld_err   <= r_ld_err | w_over;
      if (w_col_last) begin
        r_lower_bound <= r_lower_bound + LB_W'(w_row_min);
      end
    end
  end

  // Register file; a reload overwrites entries but never clears them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem[r_idx] <= w_d;
    end
  end

endmodule
